ifu_pcgen: RTL

//  Instruction-fetch PC generator, directly upstream of the instruction RAM.

---
 rtl/ifu_pcgen_pkg.sv | 27 ++
 rtl/ifu_pcgen_if.sv | 28 ++
 rtl/ifu_pcgen.sv | 108 ++++++++++
 3 files changed

// File: rtl/ifu_pcgen_pkg.sv
// Shared types, widths and helpers for the instruction-fetch PC generator.
// Fetch addresses are byte addresses; instructions are 32-bit words.
package ifu_pcgen_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t RST_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_BOOT = 2'd1,
        S_RUN  = 2'd2
    } if_state_e;

    function automatic logic is_misaligned(input inst_addr_t addr);
        return addr[1:0] != 2'b00;
    endfunction

    function automatic inst_addr_t word_align(input inst_addr_t addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_pcgen_if.sv
// Fetch-side bus between the PC generator (master) and the instruction RAM (slave).
// The RAM returns the {pc, inst} pair one cycle after a read and holds it while rd is low.
interface ifu_pcgen_if;
    import ifu_pcgen_pkg::*;

    logic       iram_busy_i;
    inst_addr_t pc_i;
    inst_t      inst_i;
    inst_addr_t pc_n_o;
    logic       iram_rd_o;

    modport master (
        input  iram_busy_i,
        input  pc_i,
        input  inst_i,
        output pc_n_o,
        output iram_rd_o
    );

    modport slave (
        output iram_busy_i,
        output pc_i,
        output inst_i,
        input  pc_n_o,
        input  iram_rd_o
    );

endinterface

// File: rtl/ifu_pcgen.sv
// Instruction-fetch PC generator: boots from RST_PC, steps sequentially, honours
// stall/jump/trap redirects and qualifies the RAM's returned pair with a valid flag.
module ifu_pcgen
    import ifu_pcgen_pkg::*;
#(
    parameter inst_addr_t RST_PC    = RST_PC_DEFAULT,
    parameter bit         ALIGN_CHK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    ifu_pcgen_if.master iram,
    input  logic       stall_i,
    input  logic       jump_i,
    input  inst_addr_t jump_addr_i,
    input  logic       trap_i,
    input  inst_addr_t trap_addr_i,
    output logic       if_valid_o,
    output inst_addr_t if_pc_o,
    output inst_t      if_inst_o,
    output logic       misalign_o
);

    if_state_e  state, state_n;
    logic       valid_r;
    logic       misalign_r;
    logic       rd;
    inst_addr_t pc_n;
    logic       run_ok;
    logic       jump_take;

    assign run_ok    = (state == S_RUN) && !iram.iram_busy_i;
    assign jump_take = run_ok && jump_i && !trap_i;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; combinational blocks below use blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) state <= S_RST;
        else     state <= state_n;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            S_RST:   if (!iram.iram_busy_i) state_n = S_BOOT;
            S_BOOT:  state_n = S_RUN;
            S_RUN:   if (iram.iram_busy_i) state_n = S_RST;
            default: state_n = S_RST;
        endcase
    end

    // Next-PC mux: trap > jump > stall > sequential. A redirect beats a stall.
    always_comb begin
        rd   = 1'b0;
        pc_n = RST_PC;
        case (state)
            S_BOOT: begin
                rd   = 1'b1;
                pc_n = RST_PC;
            end
            S_RUN: begin
                if (iram.iram_busy_i) begin
                    rd   = 1'b0;
                    pc_n = iram.pc_i;
                end else if (trap_i) begin
                    rd   = 1'b1;
                    pc_n = trap_addr_i;
                end else if (jump_i) begin
                    rd   = 1'b1;
                    pc_n = word_align(jump_addr_i);
                end else if (stall_i) begin
                    rd   = 1'b0;
                    pc_n = iram.pc_i;
                end else begin
                    rd   = 1'b1;
                    pc_n = iram.pc_i + 32'd4;
                end
            end
            default: begin
                rd   = 1'b0;
                pc_n = RST_PC;
            end
        endcase
    end

    // valid_r stays set across stalls; only reset or an iram reset hold clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            if ((state == S_RUN) && iram.iram_busy_i) valid_r <= 1'b0;
            else if (rd)                              valid_r <= 1'b1;
            misalign_r <= ALIGN_CHK && jump_take && is_misaligned(jump_addr_i);
        end
    end

    assign iram.iram_rd_o = rd;
    assign iram.pc_n_o    = pc_n;

    // The instruction presented during a redirect cycle is wrong-path.
    assign if_valid_o = valid_r && !(trap_i || jump_i);
    assign if_pc_o    = iram.pc_i;
    assign if_inst_o  = iram.inst_i;
    assign misalign_o = misalign_r;

endmodule
